// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - framed byte-stream loader for the TD4 16x8 instruction memory.
// Optional checksum byte and CHECK state are built when TD4_LOADER_CHECKSUM_EN is defined.
module td4_prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       loaded,
  output logic       err
);

`ifdef TD4_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t     r_state, w_state;
  logic       r_ready;
  logic       r_we, w_we;
  logic [3:0] r_addr, w_addr;
  logic [7:0] r_wdata, w_wdata;
  logic       r_hold, w_hold;
  logic       r_loaded, w_loaded;
  logic       r_err, w_err;
  logic [4:0] r_cnt, w_cnt;
  logic [4:0] r_n, w_n;
  logic       w_acc;
  logic       w_sync;
  logic [4:0] w_cnt_inc;
`ifdef TD4_LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_sum;
`endif

  assign w_acc     = in_valid & r_ready;
  assign w_sync    = w_acc && (in_data == SYNC_BYTE);
  assign w_cnt_inc = r_cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 4'd0;
      r_wdata  <= 8'd0;
      r_hold   <= 1'b1;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 5'd0;
      r_n      <= 5'd0;
`ifdef TD4_LOADER_CHECKSUM_EN
      r_sum    <= 8'd0;
`endif
    end else begin
      r_state  <= w_state;
      r_ready  <= 1'b1;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_hold   <= w_hold;
      r_loaded <= w_loaded;
      r_err    <= w_err;
      r_cnt    <= w_cnt;
      r_n      <= w_n;
`ifdef TD4_LOADER_CHECKSUM_EN
      r_sum    <= w_sum;
`endif
    end
  end

  always_comb begin
    w_state  = r_state;
    w_we     = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_hold   = r_hold;
    w_loaded = r_loaded;
    w_err    = r_err;
    w_cnt    = r_cnt;
    w_n      = r_n;
`ifdef TD4_LOADER_CHECKSUM_EN
    w_sum    = r_sum;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_sync) w_state = S_COUNT;
      end
      S_COUNT: begin
        if (w_acc) begin
          if ((in_data[4:0] != 5'd0) && (in_data[4:0] <= 5'd16)) begin
            w_n     = in_data[4:0];
            w_cnt   = 5'd0;
`ifdef TD4_LOADER_CHECKSUM_EN
            w_sum   = 8'd0;
`endif
            w_state = S_DATA;
          end else begin
            w_err   = 1'b1;
            w_hold  = 1'b1;
            w_state = S_ERR;
          end
        end
      end
      S_DATA: begin
        // SYNC_BYTE is ordinary data here; only the byte count ends the frame.
        if (w_acc) begin
          w_we    = 1'b1;
          w_addr  = r_cnt[3:0];
          w_wdata = in_data;
          w_cnt   = w_cnt_inc;
`ifdef TD4_LOADER_CHECKSUM_EN
          w_sum   = r_sum + in_data;
          if (w_cnt_inc == r_n) w_state = S_CHECK;
`else
          if (w_cnt_inc == r_n) begin
            w_hold   = 1'b0;
            w_loaded = 1'b1;
            w_state  = S_DONE;
          end
`endif
        end
      end
`ifdef TD4_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_acc) begin
          if (in_data == r_sum) begin
            w_hold   = 1'b0;
            w_loaded = 1'b1;
            w_state  = S_DONE;
          end else begin
            w_err    = 1'b1;
            w_state  = S_ERR;
          end
        end
      end
`endif
      S_DONE: begin
        if (w_sync) begin
          w_hold   = 1'b1;
          w_loaded = 1'b0;
          w_state  = S_COUNT;
        end
      end
      S_ERR: begin
        if (w_sync) begin
          w_err   = 1'b0;
          w_state = S_COUNT;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign in_ready  = r_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_hold  = r_hold;
  assign loaded    = r_loaded;
  assign err       = r_err;

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - randomized frame-level checking of td4_prog_loader.
// Follows TD4_LOADER_CHECKSUM_EN the same way as the design.
module tb_td4_prog_loader;

`ifdef TD4_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, mem_we, cpu_hold, loaded, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  td4_prog_loader #(.SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the cycle following the next rising edge.
  logic       exp_ready = 1'b0, exp_we = 1'b0, exp_hold = 1'b1;
  logic       exp_loaded = 1'b0, exp_err = 1'b0;
  logic [3:0] exp_addr = 4'd0;
  logic [7:0] exp_wdata = 8'd0;
  logic [7:0] mmem [16];
  logic [7:0] smem [16];
  bit         in_frame = 1'b0;
  logic [7:0] frame [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level reference: the bytes since the last frame start decide everything.
  task automatic model_accept(input logic [7:0] b);
    int n, sz;
    logic [7:0] s;
    if (!in_frame) begin
      if (b == SYNC) begin
        in_frame = 1'b1;
        frame.delete();
        exp_loaded = 1'b0;
        exp_err = 1'b0;
        exp_hold = 1'b1;
      end
      return;
    end
    frame.push_back(b);
    sz = frame.size();
    n = int'(frame[0][4:0]);
    if (n < 1 || n > 16) begin
      exp_err = 1'b1;
      in_frame = 1'b0;
    end else if (sz >= 2 && sz <= n + 1) begin
      exp_we = 1'b1;
      exp_addr = 4'(sz - 2);
      exp_wdata = b;
      mmem[sz - 2] = b;
      if (sz == n + 1 && !CK) begin
        exp_loaded = 1'b1;
        exp_hold = 1'b0;
        in_frame = 1'b0;
      end
    end else if (sz == n + 2) begin
      s = 8'd0;
      for (int i = 1; i <= n; i++) s = s + frame[i];
      if (b == s) begin
        exp_loaded = 1'b1;
        exp_hold = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
      in_frame = 1'b0;
    end
  endtask

  // Called at a falling edge: presents inputs and predicts the next rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data = d;
    exp_we = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      exp_ready = 1'b0;
      exp_hold = 1'b1;
      exp_loaded = 1'b0;
      exp_err = 1'b0;
    end else begin
      if (v && exp_ready) model_accept(d);
      exp_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat ($urandom_range(gap, 0)) step(1'b0, 8'($urandom));
    step(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] nb, input logic [7:0] d [$], input bit bad, input int gap);
    logic [7:0] s;
    s = 8'd0;
    send(SYNC, gap);
    send(nb, gap);
    foreach (d[i]) begin
      send(d[i], gap);
      s = s + d[i];
    end
    if (CK) send(bad ? (s ^ 8'h5A) : s, gap);
  endtask

  task automatic mem_check(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), smem[i], mmem[i]);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("cpu_hold", cpu_hold, exp_hold);
      chk("loaded", loaded, exp_loaded);
      chk("err", err, exp_err);
    end
    if (mem_we === 1'b1) begin
      smem[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  initial begin
    logic [7:0] q [$];
    int w0, n, cnt;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 8'd0;
      smem[i] = 8'd0;
    end
    rst = 1'b1;
    step(1'b0, 8'd0);
    chk_en = 1'b1;
    step(1'b0, 8'd0);
    chk("rst_addr", mem_addr, 4'd0);
    chk("rst_wdata", mem_wdata, 8'd0);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'd0);

    // Two-byte image.
    q = '{8'h31, 8'hB5};
    w0 = wr_cnt;
    send_frame(8'h02, q, 1'b0, 0);
    idle(2);
    chk("t1_loaded", loaded, 1'b1);
    chk("t1_hold", cpu_hold, 1'b0);
    chk("t1_m0", smem[0], 8'h31);
    chk("t1_m1", smem[1], 8'hB5);
    chk("t1_writes", wr_cnt - w0, 2);

    // Wrong checksum, then a good frame.
    send(SYNC, 0); send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
    idle(2);
    chk("t2_err", err, CK ? 1'b1 : 1'b0);
    chk("t2_loaded", loaded, CK ? 1'b0 : 1'b1);
    send(SYNC, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    idle(2);
    chk("t2b_loaded", loaded, 1'b1);
    chk("t2b_err", err, 1'b0);

    // Out-of-range counts.
    w0 = wr_cnt;
    send(SYNC, 0); send(8'h00, 0); idle(2);
    chk("t3_err0", err, 1'b1);
    send(SYNC, 0); send(8'h11, 0); idle(2);
    chk("t3_err17", err, 1'b1);
    chk("t3_hold", cpu_hold, 1'b1);
    chk("t3_nowrite", wr_cnt - w0, 0);

    // Full 16-byte image.
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    w0 = wr_cnt;
    send_frame(8'h10, q, 1'b0, 0);
    idle(2);
    chk("t4_loaded", loaded, 1'b1);
    chk("t4_writes", wr_cnt - w0, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t4_m%0d", i), smem[i], 8'(i));

    // Noise, bubbles, sync value as data.
    send(8'h00, 0); send(8'hFF, 0);
    q = '{SYNC, 8'h12, 8'h34};
    send_frame(8'h03, q, 1'b0, 3);
    idle(2);
    chk("t5_loaded", loaded, 1'b1);
    chk("t5_m0", smem[0], SYNC);
    chk("t5_m2", smem[2], 8'h34);
    mem_check("t5");

    // Reset in the middle of an N=4 frame.
    send(SYNC, 0); send(8'h04, 0); send(8'h66, 0); send(8'h77, 0);
    rst = 1'b1;
    step(1'b0, 8'd0);
    chk("t6_hold", cpu_hold, 1'b1);
    chk("t6_we", mem_we, 1'b0);
    rst = 1'b0;
    w0 = wr_cnt;
    idle(3);
    chk("t6_nowrite", wr_cnt - w0, 0);
    q = '{8'h9A, 8'hBC};
    send_frame(8'h02, q, 1'b0, 1);
    idle(2);
    chk("t6_loaded", loaded, 1'b1);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(9, 0))
        0: send(8'($urandom), 2);
        1: begin
          rst = 1'b1;
          step(1'b0, 8'd0);
          rst = 1'b0;
        end
        default: begin
          n = $urandom_range(20, 0);
          cnt = (n >= 1 && n <= 16) ? n : $urandom_range(3, 0);
          q.delete();
          for (int i = 0; i < cnt; i++)
            q.push_back(($urandom_range(4, 0) == 0) ? SYNC : 8'($urandom));
          send_frame({3'($urandom), 5'(n)}, q, $urandom_range(3, 0) == 0, 2);
        end
      endcase
    end
    idle(3);
    mem_check("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
